// File: rtl/div_secuencial.sv
// 4-bit unsigned restoring divider: one shared subtractor stepped over four
// cycles, start/busy/done handshake, divide-by-zero answered in one cycle.

module restador (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] d,
    output logic       c
);
    logic [4:0] bw;

    assign bw[0] = 1'b0;

    // ripple-borrow chain; c is the final borrow, i.e. a < b
    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign d[i]    = a[i] ^ b[i] ^ bw[i];
        assign bw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
    end

    assign c = bw[4];
endmodule

// state | meaning
// IDLE  | waiting for start
// RUN   | one restoring iteration per cycle, cnt counts 3..0
// DONE  | results valid, done pulse; start accepted here too
module div_secuencial (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] dividend,
    input  logic [3:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [3:0] quotient,
    output logic [3:0] remainder,
    output logic       div_zero
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic [3:0] rem_r, quo_r, dvs_r;
    logic [1:0] cnt;
    logic [3:0] trial, diff, rem_step;
    logic       borrow, qbit, accept;

    assign trial = {rem_r[2:0], quo_r[3]};

    restador u_sub (
        .a (trial),
        .b (dvs_r),
        .d (diff),
        .c (borrow)
    );

    // A set rem_r[3] would mean the true trial is >= 16 and must subtract;
    // it never happens for 4-bit operands but keeps the step exact.
    assign qbit     = rem_r[3] | ~borrow;
    assign rem_step = qbit ? diff : trial;
    assign accept   = start && ((state == IDLE) || (state == DONE));

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nx = (divisor == 4'd0) ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == 2'd0) state_nx = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (accept) state_nx = (divisor == 4'd0) ? DONE : RUN;
                else        state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r     <= 4'd0;
            quo_r     <= 4'd0;
            dvs_r     <= 4'd0;
            cnt       <= 2'd0;
            quotient  <= 4'd0;
            remainder <= 4'd0;
            div_zero  <= 1'b0;
        end else if (accept) begin
            if (divisor != 4'd0) begin
                rem_r <= 4'd0;
                quo_r <= dividend;
                dvs_r <= divisor;
                cnt   <= 2'd3;
            end else begin
                quotient  <= 4'hF;
                remainder <= dividend;
                div_zero  <= 1'b1;
            end
        end else if (state == RUN) begin
            rem_r <= rem_step;
            quo_r <= {quo_r[2:0], qbit};
            if (cnt == 2'd0) begin
                quotient  <= {quo_r[2:0], qbit};
                remainder <= rem_step;
                div_zero  <= 1'b0;
            end else begin
                cnt <= cnt - 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_div_secuencial.sv
// Bench for div_secuencial: directed table, handshake corner cases,
// exhaustive back-to-back sweep and random operands against / and %.

module tb_div_secuencial;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] dividend = 4'd0;
    logic [3:0] divisor = 4'd0;
    logic       busy, done, div_zero;
    logic [3:0] quotient, remainder;

    int passed = 0;
    int total  = 0;
    int done_cnt = 0;
    int overlap_cnt = 0;

    div_secuencial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (busy && done) overlap_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    // reference: plain arithmetic, divisor 0 gives q=F, r=dividend
    function automatic void ref_div(input int a, input int b,
                                    output int q, output int r, output int dz);
        if (b == 0) begin q = 15; r = a; dz = 1; end
        else        begin q = a / b; r = a % b; dz = 0; end
    endfunction

    task automatic check_div(input int a, input int b,
                             input int eq, input int er, input int edz);
        int lat, nbusy;
        string tag;
        tag = $sformatf("%0d/%0d", a, b);
        @(negedge clk);
        start = 1'b1; dividend = 4'(a); divisor = 4'(b);
        lat = -1; nbusy = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            start = 1'b0;
            dividend = 4'($urandom); divisor = 4'($urandom);
            if (busy) nbusy++;
            if (done) begin lat = k; break; end
        end
        chk({tag, " latency"}, lat, (b == 0) ? 0 : 4);
        chk({tag, " busy cycles"}, nbusy, (b == 0) ? 0 : 4);
        chk({tag, " quotient"}, int'(quotient), eq);
        chk({tag, " remainder"}, int'(remainder), er);
        chk({tag, " div_zero"}, int'(div_zero), edz);
        @(negedge clk);
        chk({tag, " done pulse width"}, int'(done), 0);
    endtask

    initial begin
        int q, r, dz, lat, d0, a, b;

        vecs[0] = '{4'd13, 4'd3, 4'd4,  4'd1, 1'b0};
        vecs[1] = '{4'd15, 4'd1, 4'd15, 4'd0, 1'b0};
        vecs[2] = '{4'd2,  4'd7, 4'd0,  4'd2, 1'b0};
        vecs[3] = '{4'd15, 4'd9, 4'd1,  4'd6, 1'b0};
        vecs[4] = '{4'd5,  4'd0, 4'hF,  4'd5, 1'b1};
        vecs[5] = '{4'd6,  4'd2, 4'd3,  4'd0, 1'b0};

        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset quotient", int'(quotient), 0);
        chk("reset remainder", int'(remainder), 0);
        chk("reset div_zero", int'(div_zero), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            check_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);

        // start during RUN must be ignored
        @(negedge clk);
        start = 1'b1; dividend = 4'd12; divisor = 4'd5;
        @(negedge clk);
        dividend = 4'd9; divisor = 4'd3;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int k = 0; k < 12; k++) begin
            if (done) begin lat = k; break; end
            @(negedge clk);
        end
        chk("run-ignore done seen", int'(lat >= 0), 1);
        chk("run-ignore quotient", int'(quotient), 2);
        chk("run-ignore remainder", int'(remainder), 2);
        @(negedge clk);
        chk("run-ignore no restart", int'(busy), 0);

        // reset in the second RUN cycle aborts the division
        @(negedge clk);
        start = 1'b1; dividend = 4'd14; divisor = 4'd4;
        @(negedge clk);
        start = 1'b0;
        chk("abort busy first cycle", int'(busy), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort quotient", int'(quotient), 0);
        chk("abort remainder", int'(remainder), 0);
        chk("abort div_zero", int'(div_zero), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        chk("abort no done", done_cnt - d0, 0);
        check_div(14, 4, 3, 2, 0);

        // exhaustive sweep, start held high so every DONE cycle re-accepts
        @(negedge clk);
        #1;
        d0 = done_cnt;
        start = 1'b1; dividend = 4'd0; divisor = 4'd0;
        for (int idx = 0; idx < 256; idx++) begin
            a = idx / 16; b = idx % 16;
            lat = -1;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (done) begin lat = k; break; end
            end
            ref_div(a, b, q, r, dz);
            chk($sformatf("sweep %0d/%0d latency", a, b), lat, (b == 0) ? 0 : 4);
            chk($sformatf("sweep %0d/%0d quotient", a, b), int'(quotient), q);
            chk($sformatf("sweep %0d/%0d remainder", a, b), int'(remainder), r);
            chk($sformatf("sweep %0d/%0d div_zero", a, b), int'(div_zero), dz);
            if (idx < 255) begin
                dividend = 4'((idx + 1) / 16);
                divisor  = 4'((idx + 1) % 16);
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        #1;
        chk("sweep done count", done_cnt - d0, 256);

        for (int n = 0; n < 40; n++) begin
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 15));
            ref_div(a, b, q, r, dz);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check_div(a, b, q, r, dz);
        end

        chk("busy and done overlap", overlap_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/div_secuencial.md
# div_secuencial

Sequential 4-bit unsigned restoring divider that schedules the shared 4-bit subtractor (`restador`) over four iteration cycles to produce quotient and remainder. It sits beside the ALU as a multi-cycle divide unit. It is driven by a start/busy/done handshake, and it detects division by zero without running the iteration loop.

## Interface
- Parameters: none. Width is fixed at 4 bits to match the subtractor.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a division. Sampled only in IDLE or DONE.
- `dividend`  in  4  unsigned dividend. Captured on the edge that accepts `start`.
- `divisor`  in  4  unsigned divisor. Captured on the edge that accepts `start`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when results become valid.
- `quotient`  out  4  registered quotient. Held until the next result.
- `remainder`  out  4  registered remainder. Held until the next result.
- `div_zero`  out  1  registered. Set with `done` when the captured divisor is 0. Held until the next result.

## Operation
- One instance of `restador` is used. A = partial remainder shifted left with the next dividend bit. B = captured divisor. Borrow flag C = 1 means A < B.
- Internal registers:
  - `rem_r` (4 bits): partial remainder.
  - `quo_r` (4 bits): doubles as the dividend shift register.
  - `dvs_r` (4 bits): captured divisor.
  - `cnt` (2 bits): iteration counter.
- States: IDLE, RUN, DONE.
- **IDLE or DONE, `start`=1, `divisor`≠0:**
  - `rem_r`=0, `quo_r`=`dividend`, `dvs_r`=`divisor`, `cnt`=3.
  - Go to RUN.
- **IDLE or DONE, `start`=1, `divisor`=0:**
  - Go to DONE directly.
  - `quotient`=4'hF, `remainder`=`dividend`, `div_zero`=1.
- **RUN, each cycle:**
  - Trial value T = {`rem_r`[2:0], `quo_r`[3]}. Subtractor computes T − `dvs_r`.
  - If C=0 (no borrow): `rem_r`=difference and the quotient bit is 1.
  - If C=1: `rem_r`=T (restore) and the quotient bit is 0.
  - `quo_r` = {`quo_r`[2:0], quotient bit}.
- **RUN with `cnt`=0:**
  - Go to DONE.
  - Load `quotient`/`remainder` from the updated `quo_r`/`rem_r`. `div_zero`=0.
  - Otherwise decrement `cnt`.
- **DONE:** `done`=1 for exactly that cycle. Return to IDLE unless `start` is accepted.
- Width rule:
  - The partial remainder before each shift is below 2^i and below `divisor`, so T never exceeds 15.
  - No fifth remainder bit is required.
  - The subtractor's V output is ignored.
- `start` during RUN is ignored. Operands on the inputs during RUN have no effect.
- `quotient`/`remainder`/`div_zero` change only on the edge entering DONE.

## Timing
- Reset (async assert, any state): state=IDLE; `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_zero`=0; internal registers cleared.
- Reset release takes effect at the next `clk` edge. An aborted division produces no `done`.
- Edge 0 accepts `start` with a nonzero divisor:
  - `busy`=1 after edges 0 to 3.
  - Iterations occur at edges 1 to 4.
  - After edge 4: `done`=1, `busy`=0, results valid.
  - Result latency is 4 cycles from acceptance.
- Divide-by-zero: `done` and `div_zero` are high after edge 0. Latency is 1 cycle and `busy` never rises.
- Back-to-back: `start` high during the DONE cycle is accepted. `busy` rises on the next edge and there is no IDLE bubble.
- `busy` and `done` are never high in the same cycle.

## Test plan
- 13 / 3, `start` pulse → `busy` for 4 cycles, then `done`=1 with `quotient`=4, `remainder`=1, `div_zero`=0.
- 15 / 1 → `quotient`=15, `remainder`=0. Then 2 / 7 → `quotient`=0, `remainder`=2. Then 15 / 9 → `quotient`=1, `remainder`=6.
- 5 / 0 → `done` one cycle after acceptance, `busy` never high, `div_zero`=1, `quotient`=4'hF, `remainder`=5. A following 6 / 2 clears `div_zero` and gives `quotient`=3, `remainder`=0.
- 12 / 5 started, then `start` with 9 / 3 during RUN → ignored, result is `quotient`=2, `remainder`=2.
- `rst_n` low in the second RUN cycle of 14 / 4 → all outputs 0 immediately, no `done`. After release, 14 / 4 yields `quotient`=3, `remainder`=2.
- Exhaustive sweep: all 256 operand pairs, `start` asserted in every DONE cycle → every result matches the `/` and `%` reference. Divisor 0 follows the divide-by-zero rule. Exactly one `done` per accepted `start`.
